// File: rtl/fir_result_sink_pkg.sv
// Shared definitions for the FIR result sink: register map, ctrl/status bit
// positions and the capture FSM state encoding.
package fir_result_sink_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_LEN   = 8'h10;
  localparam logic [7:0] ADDR_COUNT = 8'h14;
  localparam logic [7:0] ADDR_CSUM  = 8'h18;
  localparam logic [7:0] ADDR_STALL = 8'h1C;
  localparam logic [7:0] ADDR_LAST  = 8'h20;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_DONE_BIT    = 1;
  localparam int CTRL_IDLE_BIT    = 2;
  localparam int CTRL_LEN_ERR_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sink_state_e;

endpackage

// File: rtl/fir_result_sink_axil.sv
// Minimal AXI-Lite register slave: one-cycle write/read accept pulses and a
// registered read response, exposing a simple strobe-based register port.
module fir_result_sink_axil #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   awready,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rready,
  output logic                   arready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   reg_wr_en,
  output logic [pADDR_WIDTH-1:0] reg_wr_addr,
  output logic [pDATA_WIDTH-1:0] reg_wr_data,
  output logic                   reg_rd_en,
  output logic [pADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [pDATA_WIDTH-1:0] reg_rd_data
);

  logic                   aw_ready_r;
  logic                   ar_ready_r;
  logic                   rvalid_r;
  logic [pDATA_WIDTH-1:0] rdata_r;

  // Register-side strobes fire on the handshake edge itself.
  assign reg_wr_en   = aw_ready_r && awvalid && wvalid;
  assign reg_wr_addr = awaddr;
  assign reg_wr_data = wdata;
  assign reg_rd_en   = ar_ready_r && arvalid;
  assign reg_rd_addr = araddr;

  assign awready = aw_ready_r;
  assign wready  = aw_ready_r;
  assign arready = ar_ready_r;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;

  // Handshake pulses and read response holding register.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      aw_ready_r <= 1'b0;
      ar_ready_r <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= '0;
    end else begin
      aw_ready_r <= awvalid && wvalid && !aw_ready_r;
      ar_ready_r <= arvalid && !ar_ready_r && !rvalid_r;
      if (reg_rd_en) begin
        rvalid_r <= 1'b1;
        rdata_r  <= reg_rd_data;
      end else if (rvalid_r && rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_result_sink.sv
// FIR output capture block: counts, checksums and records the last sample of
// a stream run, with length checking and optional periodic backpressure.
module fir_result_sink
  import fir_result_sink_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst,
  input  logic                          awvalid,
  input  logic [pADDR_WIDTH-1:0]        awaddr,
  input  logic                          wvalid,
  input  logic [pDATA_WIDTH-1:0]        wdata,
  output logic                          awready,
  output logic                          wready,
  input  logic                          arvalid,
  input  logic [pADDR_WIDTH-1:0]        araddr,
  input  logic                          rready,
  output logic                          arready,
  output logic                          rvalid,
  output logic [pDATA_WIDTH-1:0]        rdata,
  input  logic                          sm_tvalid,
  input  logic signed [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                          sm_tlast,
  output logic                          sm_tready
);

  localparam logic [pDATA_WIDTH-1:0] ONE_W = pDATA_WIDTH'(1);

  logic                   wr_en_s, rd_en_s;
  logic [pADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic [pDATA_WIDTH-1:0] wr_data_s, rd_data_s;

  sink_state_e            state_r, state_nxt_s;
  logic [pDATA_WIDTH-1:0] len_r, len_nxt_s;
  logic [pDATA_WIDTH-1:0] act_len_r, act_len_nxt_s;
  logic [pDATA_WIDTH-1:0] count_r, count_nxt_s;
  logic [pDATA_WIDTH-1:0] csum_r, csum_nxt_s;
  logic [pDATA_WIDTH-1:0] last_r, last_nxt_s;
  logic [7:0]             stall_r, stall_nxt_s;
  logic [7:0]             rdy_cnt_r, rdy_cnt_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   len_err_r, len_err_nxt_s;
  logic                   tready_r, tready_nxt_s;
  logic                   beat_s, start_s;
  logic [pDATA_WIDTH-1:0] cnt_inc_s;

  fir_result_sink_axil #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_axil (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .awvalid     (awvalid),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wdata       (wdata),
    .awready     (awready),
    .wready      (wready),
    .arvalid     (arvalid),
    .araddr      (araddr),
    .rready      (rready),
    .arready     (arready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .reg_wr_en   (wr_en_s),
    .reg_wr_addr (wr_addr_s),
    .reg_wr_data (wr_data_s),
    .reg_rd_en   (rd_en_s),
    .reg_rd_addr (rd_addr_s),
    .reg_rd_data (rd_data_s)
  );

  assign sm_tready = tready_r;
  assign beat_s    = (state_r == ST_RUN) && sm_tvalid && tready_r;
  assign cnt_inc_s = count_r + ONE_W;
  assign start_s   = wr_en_s && (wr_addr_s == pADDR_WIDTH'(ADDR_CTRL)) && wr_data_s[CTRL_START_BIT];

  // Register read mux; status reflects the cycle in which arready is high.
  always_comb begin
    rd_data_s = '0;
    case (rd_addr_s)
      pADDR_WIDTH'(ADDR_CTRL): begin
        rd_data_s[CTRL_DONE_BIT]    = done_r;
        rd_data_s[CTRL_IDLE_BIT]    = (state_r != ST_RUN);
        rd_data_s[CTRL_LEN_ERR_BIT] = len_err_r;
      end
      pADDR_WIDTH'(ADDR_LEN):   rd_data_s = len_r;
      pADDR_WIDTH'(ADDR_COUNT): rd_data_s = count_r;
      pADDR_WIDTH'(ADDR_CSUM):  rd_data_s = csum_r;
      pADDR_WIDTH'(ADDR_STALL): rd_data_s = pDATA_WIDTH'(stall_r);
      pADDR_WIDTH'(ADDR_LAST):  rd_data_s = last_r;
      default:                  rd_data_s = '0;
    endcase
  end

  // FSM next state and all datapath next values.
  always_comb begin
    state_nxt_s   = state_r;
    act_len_nxt_s = act_len_r;
    count_nxt_s   = count_r;
    csum_nxt_s    = csum_r;
    last_nxt_s    = last_r;
    len_err_nxt_s = len_err_r;
    done_nxt_s    = done_r;
    tready_nxt_s  = 1'b0;
    rdy_cnt_nxt_s = 8'd0;

    if (wr_en_s && (wr_addr_s == pADDR_WIDTH'(ADDR_LEN))) begin
      len_nxt_s = wr_data_s;
    end else begin
      len_nxt_s = len_r;
    end
    if (wr_en_s && (wr_addr_s == pADDR_WIDTH'(ADDR_STALL))) begin
      stall_nxt_s = wr_data_s[7:0];
    end else begin
      stall_nxt_s = stall_r;
    end
    // Clear-on-read; a completion in the same cycle still sets done below.
    if (rd_en_s && (rd_addr_s == pADDR_WIDTH'(ADDR_CTRL)) && done_r) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          count_nxt_s   = '0;
          csum_nxt_s    = '0;
          last_nxt_s    = '0;
          len_err_nxt_s = 1'b0;
          act_len_nxt_s = len_r;
          if (len_r == '0) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
            done_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (beat_s) begin
          count_nxt_s = cnt_inc_s;
          csum_nxt_s  = csum_r + sm_tdata;
          last_nxt_s  = sm_tdata;
          if (sm_tlast || (cnt_inc_s == act_len_r)) begin
            state_nxt_s   = ST_DONE;
            done_nxt_s    = 1'b1;
            len_err_nxt_s = sm_tlast ? (cnt_inc_s != act_len_r) : 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    // One stall cycle after every stall_r consecutive ready cycles.
    if (state_nxt_s == ST_RUN) begin
      if (stall_r == 8'd0) begin
        tready_nxt_s = 1'b1;
      end else if (!tready_r || (state_r != ST_RUN)) begin
        tready_nxt_s = 1'b1;
      end else if ((rdy_cnt_r + 8'd1) == stall_r) begin
        tready_nxt_s = 1'b0;
      end else begin
        tready_nxt_s  = 1'b1;
        rdy_cnt_nxt_s = rdy_cnt_r + 8'd1;
      end
    end else begin
      tready_nxt_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      len_r     <= '0;
      act_len_r <= '0;
      count_r   <= '0;
      csum_r    <= '0;
      last_r    <= '0;
      stall_r   <= 8'd0;
      rdy_cnt_r <= 8'd0;
      done_r    <= 1'b0;
      len_err_r <= 1'b0;
      tready_r  <= 1'b0;
    end else begin
      len_r     <= len_nxt_s;
      act_len_r <= act_len_nxt_s;
      count_r   <= count_nxt_s;
      csum_r    <= csum_nxt_s;
      last_r    <= last_nxt_s;
      stall_r   <= stall_nxt_s;
      rdy_cnt_r <= rdy_cnt_nxt_s;
      done_r    <= done_nxt_s;
      len_err_r <= len_err_nxt_s;
      tready_r  <= tready_nxt_s;
    end
  end

endmodule
